corescore_gatemate_rst_gen: RTL and testbench

CORESCORE_GATEMATE_RST_GEN -- requirements
Module: corescore_gatemate_rst_gen

---
 rtl/corescore_gatemate_pkg.sv | 16 +
 rtl/corescore_gatemate_sync2.sv | 21 ++
 rtl/corescore_gatemate_rst_gen.sv | 83 ++++++++
 tb/tb_corescore_gatemate_rst_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/corescore_gatemate_pkg.sv
// corescore_gatemate_pkg: shared FSM state encodings and counter width for the reset generator
package corescore_gatemate_pkg;
  localparam int CNT_W = 16;
  localparam logic [2:0] ST_POR       = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_DEB_PRESS = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_DEB_REL   = 3'd4;
  typedef enum logic [2:0] {
    POR       = ST_POR,
    IDLE      = ST_IDLE,
    DEB_PRESS = ST_DEB_PRESS,
    HOLD      = ST_HOLD,
    DEB_REL   = ST_DEB_REL
  } state_t;
endpackage

// File: rtl/corescore_gatemate_sync2.sv
// corescore_gatemate_sync2: 2-flop synchronizer; i_clk, i_rst (async, high) -> resets to RST_VAL; i_d async in, o_q synced out
module corescore_gatemate_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_q1, r_q2;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q1 <= RST_VAL;
      r_q2 <= RST_VAL;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end
  assign o_q = r_q2;
endmodule

// File: rtl/corescore_gatemate_rst_gen.sv
// corescore_gatemate_rst_gen: power-on + debounced button reset; i_clk, i_rst, i_btn_n in -> o_rst, o_press_cnt out
module corescore_gatemate_rst_gen
  import corescore_gatemate_pkg::*;
#(
  parameter int unsigned POR_CYCLES   = 1024,
  parameter int unsigned DEB_CYCLES   = 50000,
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_n,
  output logic       o_rst,
  output logic [7:0] o_press_cnt
);
  localparam logic [CNT_W-1:0] POR_MAX   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_MAX = CNT_W'(PULSE_CYCLES - 1);
  logic             w_btn_s;
  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             w_acc;
  logic             r_rst;
  logic [7:0]       r_press_cnt;
  corescore_gatemate_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_btn_n),
    .o_q   (w_btn_s)
  );
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_acc     = 1'b0;
    case (r_state)
      POR: if (r_cnt == POR_MAX) begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
      IDLE: begin
        w_cnt_n = '0;
        if (!w_btn_s) w_state_n = DEB_PRESS;
      end
      DEB_PRESS: if (w_btn_s) begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end else if (r_cnt == DEB_MAX) begin
        w_state_n = HOLD;
        w_cnt_n   = '0;
        w_acc     = 1'b1;
      end
      HOLD: if (r_cnt == PULSE_MAX) begin
        w_state_n = DEB_REL;
        w_cnt_n   = '0;
      end
      DEB_REL: if (!w_btn_s) begin
        w_cnt_n = '0;
      end else if (r_cnt == DEB_MAX) begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = POR;
        w_cnt_n   = '0;
      end
    endcase
  end
  // o_rst is registered from the next state so it changes on the same edge as the state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= POR;
      r_cnt       <= '0;
      r_rst       <= 1'b1;
      r_press_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rst   <= (w_state_n == POR) || (w_state_n == HOLD) || (w_state_n == DEB_REL);
      if (w_acc && r_press_cnt != 8'hff) r_press_cnt <= r_press_cnt + 8'd1;
    end
  end
  assign o_rst       = r_rst;
  assign o_press_cnt = r_press_cnt;
endmodule

// File: tb/tb_corescore_gatemate_rst_gen.sv
// tb_corescore_gatemate_rst_gen: directed table-driven bench for the reset generator
module tb_corescore_gatemate_rst_gen;
  typedef struct {
    logic       btn;
    logic       rst;
    logic [7:0] cnt;
  } vec_t;
  logic       clk = 1'b0;
  logic       i_rst, i_btn_n, o_rst;
  logic [7:0] o_press_cnt;
  int         n_pass = 0;
  int         n_tot = 0;
  vec_t       tbl[48];
  always #5 clk = ~clk;
  corescore_gatemate_rst_gen #(
    .POR_CYCLES   (8),
    .DEB_CYCLES   (4),
    .PULSE_CYCLES (3)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_btn_n     (i_btn_n),
    .o_rst       (o_rst),
    .o_press_cnt (o_press_cnt)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic por_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_por_high"}, int'(o_rst), 1);
      @(negedge clk);
    end
    chk({tag, "_por_low"}, int'(o_rst), 0);
  endtask
  initial begin
    int w;
    int k;
    int exp_c;
    for (int s = 0; s < 18; s++) tbl[s] = '{btn: (s < 15) ? ((s % 3) == 2) : 1'b1, rst: 1'b0, cnt: 8'd0};
    for (int s = 1; s <= 30; s++) tbl[17 + s] = '{btn: (s > 20), rst: (s >= 7 && s <= 25), cnt: (s >= 7) ? 8'd1 : 8'd0};
    i_rst   = 1'b1;
    i_btn_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_o_rst", int'(o_rst), 1);
    chk("reset_press_cnt", int'(o_press_cnt), 0);
    i_rst = 1'b0;
    por_check("init");
    chk("init_press_cnt", int'(o_press_cnt), 0);
    for (int s = 0; s < 48; s++) begin
      i_btn_n = tbl[s].btn;
      @(negedge clk);
      chk($sformatf("vec%0d_o_rst", s), int'(o_rst), int'(tbl[s].rst));
      chk($sformatf("vec%0d_press_cnt", s), int'(o_press_cnt), int'(tbl[s].cnt));
    end
    i_btn_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("hold_o_rst", int'(o_rst), 1);
    chk("hold_press_cnt", int'(o_press_cnt), 2);
    i_rst   = 1'b1;
    i_btn_n = 1'b1;
    #1;
    chk("midrst_o_rst", int'(o_rst), 1);
    chk("midrst_press_cnt", int'(o_press_cnt), 0);
    @(negedge clk);
    i_rst = 1'b0;
    por_check("midrst");
    i_rst   = 1'b1;
    i_btn_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    por_check("heldbtn");
    for (int j = 9; j <= 12; j++) begin
      @(negedge clk);
      chk($sformatf("heldbtn_e%0d_low", j), int'(o_rst), 0);
    end
    @(negedge clk);
    chk("heldbtn_e13_high", int'(o_rst), 1);
    chk("heldbtn_press_cnt", int'(o_press_cnt), 1);
    i_btn_n = 1'b1;
    k = 0;
    while (o_rst && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("heldbtn_release_done", int'(o_rst), 0);
    for (int p = 0; p < 260; p++) begin
      w = 0;
      for (int c = 1; c <= 30; c++) begin
        i_btn_n = (c > 10);
        @(negedge clk);
        if (o_rst) w++;
      end
      exp_c = (p + 2 > 255) ? 255 : p + 2;
      chk($sformatf("press%0d_pulse_width", p), w, 9);
      chk($sformatf("press%0d_press_cnt", p), int'(o_press_cnt), exp_c);
    end
    chk("saturated_press_cnt", int'(o_press_cnt), 255);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
